icache_line_fetch_ctrl: RTL and testbench
=========================================

// Module: icache_line_fetch_ctrl
// PURPOSE
// - Refill controller for the single-line instruction fetch buffer; instantiates presence_check.
// - Decides per fetch request: hit, wait on in-flight refill, or issue a new line refill.
// - Drives the memory request/response handshake and tracks the line tag and valid bit.
// - Manages flush/discard. Sits between the fetch stage and the instruction memory port.
// PARAMETERS
// - LINE_W      128  line width in bits; equals 8 << (ICACHE_OFFSET+OFFSET)
// - PERF_CNT_W  32   performance counter width; used only with LINE_FETCH_PERF_EN
// PORTS
// - clk_i            in   1       clock, rising edge
// - rst_n_i          in   1       reset, asynchronous, active-low
// - flush_i          in   1       invalidate line, discard any in-flight refill
// - fetch_valid_i    in   1       fetch stage requests instruction at pc_i
// - pc_i             in   XLEN    fetch PC
// - fetch_hit_o      out  1       line holding pc_i is valid this cycle (combinational)
// - line_pc_o        out  XLEN    tag PC of buffered line
// - line_valid_o     out  1       buffered line valid
// - line_we_o        out  1       one-cycle write strobe to line data buffer
// - line_data_o      out  LINE_W  refill data, mem_resp_data_i passthrough
// - mem_req_valid_o  out  1       refill request valid
// - mem_req_ready_i  in   1       memory accepts request
// - mem_req_addr_o   out  XLEN    line-aligned refill address
// - mem_resp_valid_i in   1       refill data valid; single beat, always accepted
// - mem_resp_data_i  in   LINE_W  refill data
// BEHAVIOUR
// - Reset: state IDLE; line_pc, req_pc = 0; line_valid, discard = 0; all outputs 0.
// - presence_check inputs: pc_i, prev_pc_i=req_pc, line_pc, line_valid.
// - wbh = will_be_here_o & pending & !discard; pending = state in {REQ, WAIT}.
// - fetch_hit_o = here_o & fetch_valid_i.
// - FSM IDLE: fetch_valid_i & !here & !wbh -> REQ; req_pc <= pc_i.
// - FSM REQ: mem_req_valid_o=1; addr/valid held stable until mem_req_ready_i; then -> WAIT.
// - FSM REQ: valid never deasserts before acceptance, even on flush.
// - FSM WAIT: on mem_resp_valid_i -> IDLE.
// - FSM WAIT: if !discard -> line_we_o=1, line_pc<=req_pc, line_valid<=1; else no write.
// - mem_req_addr_o = {req_pc[XLEN-1:ICACHE_OFFSET+OFFSET], '0}.
// - Latency: miss -> mem_req_valid_o in next cycle; refill -> fetch_hit_o in next cycle.
// - flush_i: line_valid<=0. In REQ/WAIT: discard<=1. discard clears on return to IDLE.
// - flush_i with mem_resp_valid_i in same cycle: discard wins, no line write.
// - fetch_valid_i for in-flight line: wbh=1, no new request; hit follows refill.
// - Differing PC while pending: no action until IDLE; fetch stage keeps fetch_valid_i up.
// - Responses only in WAIT; mem_resp_valid_i in IDLE/REQ is ignored (protocol error).
// - Reset mid-refill: state to IDLE; late responses then ignored as above.
// CONFIGURATION
// - Macro LINE_FETCH_PERF_EN.
// - Defined: adds perf_hit_cnt_o, perf_miss_cnt_o (PERF_CNT_W each), saturating, reset 0.
//   Hit counts fetch_hit_o cycles; miss counts IDLE->REQ transitions.
// - Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
// - mmm_pkg: XLEN, ICACHE_OFFSET, OFFSET (existing); add ICACHE_LINE_W.
// - mmm_pkg: add typedef enum logic [1:0] {IDLE, REQ, WAIT} line_fetch_state_t.
// - Sub-module: one presence_check instance; FSM, tag and counters local.
// TESTING
// - Cold miss, pc=0x1004: REQ next cycle, addr=0x1000; ready, resp=D -> line_we_o=1; hit next.
// - Back-to-back pc 0x1004, 0x1008 -> second is fetch_hit_o=1, no mem request.
// - Miss 0x2000; mem_req_ready_i low 5 cycles -> valid/addr stable 5 cycles; one request only.
// - Refill 0x3000 in flight; pc=0x3008 -> no 2nd request; hit after response.
// - Flush in WAIT -> resp ignored, line_valid_o=0; same pc -> new request 0x3000.
// - Flush + mem_resp_valid_i same cycle -> no write. PERF_EN: 3 hits, 2 misses -> counters 3/2.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared fetch-path definitions: address width, line geometry and the
// line refill FSM state encoding.
package mmm_pkg;

    localparam int XLEN          = 32;
    localparam int OFFSET        = 2;   // byte offset within an instruction word
    localparam int ICACHE_OFFSET = 2;   // word offset within a line
    localparam int LINE_TAG_LSB  = ICACHE_OFFSET + OFFSET;
    localparam int ICACHE_LINE_W = 8 << LINE_TAG_LSB;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } line_fetch_state_t;

    // Clear the within-line offset bits of an address.
    function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] m;
        m = '1;
        m[LINE_TAG_LSB-1:0] = '0;
        return a & m;
    endfunction

endpackage

// File: rtl/icache_line_fetch_ctrl_presence_check.sv
// presence_check: line-granular tag compare for the single-line fetch buffer.
// here_o           - pc_i falls in the currently valid buffered line.
// will_be_here_o   - pc_i falls in the line last requested from memory.
module presence_check
    import mmm_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] prev_pc_i,
    input  logic [XLEN-1:0] line_pc_i,
    input  logic            line_valid_i,
    output logic            here_o,
    output logic            will_be_here_o
);

    assign here_o         = line_valid_i && (line_align(pc_i) == line_align(line_pc_i));
    assign will_be_here_o = (line_align(pc_i) == line_align(prev_pc_i));

endmodule

// File: rtl/icache_line_fetch_ctrl.sv
// icache_line_fetch_ctrl: refill controller for the single-line instruction
// fetch buffer. Classifies each fetch as hit / wait-on-refill / new miss,
// runs the memory request/response handshake and owns the line tag + valid.
// Optional build macro LINE_FETCH_PERF_EN adds saturating hit/miss counters.
module icache_line_fetch_ctrl
    import mmm_pkg::*;
#(
    parameter int LINE_W = ICACHE_LINE_W
`ifdef LINE_FETCH_PERF_EN
    ,
    parameter int PERF_CNT_W = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              fetch_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              fetch_hit_o,
    output logic [XLEN-1:0]   line_pc_o,
    output logic              line_valid_o,
    output logic              line_we_o,
    output logic [LINE_W-1:0] line_data_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_req_addr_o,
    input  logic              mem_resp_valid_i,
    input  logic [LINE_W-1:0] mem_resp_data_i
`ifdef LINE_FETCH_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_hit_cnt_o,
    output logic [PERF_CNT_W-1:0] perf_miss_cnt_o
`endif
);

    line_fetch_state_t state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   line_pc_q, line_pc_d;
    logic              line_valid_q, line_valid_d;
    logic              discard_q, discard_d;

    logic here, will_be_here, pending, wbh, miss_start;

    presence_check u_presence (
        .pc_i          (pc_i),
        .prev_pc_i     (req_pc_q),
        .line_pc_i     (line_pc_q),
        .line_valid_i  (line_valid_q),
        .here_o        (here),
        .will_be_here_o(will_be_here)
    );

    // A refill is pending from request issue until its response; a discarded
    // refill no longer counts as bringing the line in.
    assign pending     = (state_q == REQ) || (state_q == WAIT);
    assign wbh         = will_be_here && pending && !discard_q;
    assign fetch_hit_o = here && fetch_valid_i;

    assign line_pc_o      = line_pc_q;
    assign line_valid_o   = line_valid_q;
    assign line_data_o    = mem_resp_data_i;
    assign mem_req_addr_o = line_align(req_pc_q);

    // State, tag and discard registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            req_pc_q     <= '0;
            line_pc_q    <= '0;
            line_valid_q <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            line_pc_q    <= line_pc_d;
            line_valid_q <= line_valid_d;
            discard_q    <= discard_d;
        end
    end

    // Next-state, request/write strobes, flush handling.
    always_comb begin
        state_d         = state_q;
        req_pc_d        = req_pc_q;
        line_pc_d       = line_pc_q;
        line_valid_d    = line_valid_q;
        discard_d       = discard_q;
        mem_req_valid_o = 1'b0;
        line_we_o       = 1'b0;
        miss_start      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fetch_valid_i && !here && !wbh) begin
                    state_d    = REQ;
                    req_pc_d   = pc_i;
                    miss_start = 1'b1;
                end
            end
            REQ: begin
                // Held regardless of flush: once raised, the request must complete.
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                    // A flush arriving with the data also kills the write.
                    if (!discard_q && !flush_i) begin
                        line_we_o    = 1'b1;
                        line_pc_d    = req_pc_q;
                        line_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            line_valid_d = 1'b0;
            if (pending) discard_d = 1'b1;
        end
        if (state_d == IDLE) discard_d = 1'b0;
    end

`ifdef LINE_FETCH_PERF_EN
    logic [PERF_CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;

    // Saturating counters: hit cycles and IDLE->REQ transitions.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (fetch_hit_o && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + PERF_CNT_W'(1);
            if (miss_start && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_icache_line_fetch_ctrl.sv
// Bench for icache_line_fetch_ctrl: table of fetch vectors plus hand-written
// flush / in-flight / reset sequences; request addresses and line writes are
// checked against a scoreboard queue by a negedge monitor.
module tb_icache_line_fetch_ctrl;
    import mmm_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         fetch_valid_i = 1'b0;
    logic [31:0]  pc_i = '0;
    logic         mem_req_ready_i = 1'b0;
    logic         mem_resp_valid_i = 1'b0;
    logic [127:0] mem_resp_data_i = '0;
    logic         fetch_hit_o, line_valid_o, line_we_o, mem_req_valid_o;
    logic [31:0]  line_pc_o, mem_req_addr_o;
    logic [127:0] line_data_o;
`ifdef LINE_FETCH_PERF_EN
    logic [31:0]  perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0]  addr_q[$];
    logic [127:0] data_q[$];

    typedef struct {
        logic [31:0]  pc;
        logic         exp_hit;
        int           dly;
        logic [127:0] data;
    } vec_t;
    vec_t vecs[8];

    icache_line_fetch_ctrl dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .fetch_valid_i   (fetch_valid_i),
        .pc_i            (pc_i),
        .fetch_hit_o     (fetch_hit_o),
        .line_pc_o       (line_pc_o),
        .line_valid_o    (line_valid_o),
        .line_we_o       (line_we_o),
        .line_data_o     (line_data_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i (mem_resp_data_i)
`ifdef LINE_FETCH_PERF_EN
        ,
        .perf_hit_cnt_o  (perf_hit_cnt_o),
        .perf_miss_cnt_o (perf_miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] pc);
        return {pc[31:4], 4'h0};
    endfunction

    function automatic logic [127:0] mkdata(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, ~pc, pc ^ 32'h0F0F_0F0F, pc + 32'h1111};
    endfunction

    // Scoreboard monitor: every accepted request and every line write must
    // match the next queued expectation.
    always @(negedge clk_i) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req got %0h want none", mem_req_addr_o);
            end else check("req_addr_sb", mem_req_addr_o, addr_q.pop_front());
        end
        if (line_we_o) begin
            if (data_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_we got %0h want none", line_data_o);
            end else check("line_data_sb", line_data_o, data_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    // Called at a drive point while in REQ; leaves the FSM in WAIT.
    task automatic handshake();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic respond(input logic [127:0] d, input logic exp_we);
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = d;
        @(negedge clk_i);
        check("resp_we", line_we_o, exp_we);
        tick();
        mem_resp_valid_i = 1'b0;
    endtask

    // Single-cycle fetch pulse that starts a refill; leaves the FSM in REQ.
    task automatic issue_miss(input logic [31:0] pc);
        tick();
        fetch_valid_i = 1'b1; pc_i = pc;
        addr_q.push_back(exp_addr(pc));
        @(negedge clk_i);
        check("miss_no_hit", fetch_hit_o, 1'b0);
        tick();
        fetch_valid_i = 1'b0;
    endtask

    // Full fetch with the fetch stage holding fetch_valid_i until the hit.
    task automatic do_fetch(input logic [31:0] pc, input logic exp_hit, input int dly,
                            input logic [127:0] d);
        tick();
        fetch_valid_i = 1'b1; pc_i = pc;
        @(negedge clk_i);
        check("fetch_hit", fetch_hit_o, exp_hit);
        if (!exp_hit) begin
            addr_q.push_back(exp_addr(pc));
            data_q.push_back(d);
            @(negedge clk_i);
            check("req_latency", mem_req_valid_o, 1'b1);
            check("req_addr", mem_req_addr_o, exp_addr(pc));
            for (int i = 1; i < dly; i++) begin
                @(negedge clk_i);
                check("req_hold_valid", mem_req_valid_o, 1'b1);
                check("req_hold_addr", mem_req_addr_o, exp_addr(pc));
            end
            tick();
            handshake();
            @(negedge clk_i);
            check("req_dropped", mem_req_valid_o, 1'b0);
            tick();
            respond(d, 1'b1);
            @(negedge clk_i);
            check("hit_after_refill", fetch_hit_o, 1'b1);
            check("line_pc", line_pc_o, pc);
            check("line_valid", line_valid_o, 1'b1);
        end
        tick();
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_1004, 1'b0, 0, mkdata(32'h1004)};
        vecs[1] = '{32'h0000_1008, 1'b1, 0, '0};
        vecs[2] = '{32'h0000_100C, 1'b1, 0, '0};
        vecs[3] = '{32'h0000_2000, 1'b0, 5, mkdata(32'h2000)};
        vecs[4] = '{32'h0000_2004, 1'b1, 0, '0};
        vecs[5] = '{32'h0000_1000, 1'b0, 2, mkdata(32'h1000)};
        vecs[6] = '{32'h0000_100F, 1'b1, 0, '0};
        vecs[7] = '{32'h0000_2000, 1'b0, 0, mkdata(32'h2000)};

        // Reset state
        @(negedge clk_i);
        check("rst_hit", fetch_hit_o, 1'b0);
        check("rst_line_valid", line_valid_o, 1'b0);
        check("rst_line_pc", line_pc_o, 32'h0);
        check("rst_we", line_we_o, 1'b0);
        check("rst_req_valid", mem_req_valid_o, 1'b0);
        check("rst_req_addr", mem_req_addr_o, 32'h0);
        tick();
        rst_n_i = 1'b1;

        for (int v = 0; v < 8; v++)
            do_fetch(vecs[v].pc, vecs[v].exp_hit, vecs[v].dly, vecs[v].data);

        // Refill of 0x3000 in flight, fetch moves to 0x3008: no second request
        tick();
        fetch_valid_i = 1'b1; pc_i = 32'h3000;
        addr_q.push_back(32'h3000); data_q.push_back(mkdata(32'h3000));
        @(negedge clk_i);
        check("inflight_first_hit", fetch_hit_o, 1'b0);
        tick();
        pc_i = 32'h3008;
        @(negedge clk_i);
        check("inflight_addr", mem_req_addr_o, 32'h3000);
        tick();
        handshake();
        @(negedge clk_i);
        check("inflight_no_req", mem_req_valid_o, 1'b0);
        check("inflight_wait_hit", fetch_hit_o, 1'b0);
        tick();
        respond(mkdata(32'h3000), 1'b1);
        @(negedge clk_i);
        check("inflight_hit", fetch_hit_o, 1'b1);
        check("inflight_line_pc", line_pc_o, 32'h3000);
        tick();
        fetch_valid_i = 1'b0;

        // Flush in IDLE, then flush during WAIT discards the response
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_idle_valid", line_valid_o, 1'b0);
        issue_miss(32'h3000);
        handshake();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        respond(mkdata(32'h3000), 1'b0);
        @(negedge clk_i);
        check("discard_line_valid", line_valid_o, 1'b0);
        do_fetch(32'h3000, 1'b0, 1, mkdata(32'h3000) ^ 128'h1);

        // Flush coinciding with the response: no write
        issue_miss(32'h5000);
        handshake();
        flush_i = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = mkdata(32'h5000);
        @(negedge clk_i);
        check("flush_resp_we", line_we_o, 1'b0);
        tick();
        flush_i = 1'b0; mem_resp_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_resp_valid", line_valid_o, 1'b0);
        check("flush_resp_idle", mem_req_valid_o, 1'b0);

        // Response in IDLE is ignored
        do_fetch(32'h5000, 1'b0, 0, mkdata(32'h5000));
        tick();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = mkdata(32'h9999);
        @(negedge clk_i);
        check("idle_resp_we", line_we_o, 1'b0);
        tick();
        mem_resp_valid_i = 1'b0;
        @(negedge clk_i);
        check("idle_resp_line_pc", line_pc_o, 32'h5000);
        check("idle_resp_valid", line_valid_o, 1'b1);

        // Reset mid-refill; the late response must not write
        issue_miss(32'h6000);
        handshake();
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("midrst_req_valid", mem_req_valid_o, 1'b0);
        check("midrst_line_valid", line_valid_o, 1'b0);
        check("midrst_req_addr", mem_req_addr_o, 32'h0);
        tick();
        rst_n_i = 1'b1;
        respond(mkdata(32'h6000), 1'b0);
        @(negedge clk_i);
        check("midrst_after_valid", line_valid_o, 1'b0);

`ifdef LINE_FETCH_PERF_EN
        tick(); rst_n_i = 1'b0; tick(); rst_n_i = 1'b1;
        do_fetch(32'h7000, 1'b0, 0, mkdata(32'h7000));
        do_fetch(32'h7004, 1'b1, 0, '0);
        do_fetch(32'h8000, 1'b0, 2, mkdata(32'h8000));
        @(negedge clk_i);
        check("perf_hits", perf_hit_cnt_o, 32'd3);
        check("perf_misses", perf_miss_cnt_o, 32'd2);
`endif

        tick();
        check("addr_q_drained", addr_q.size(), 0);
        check("data_q_drained", data_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
